// File: rtl/ibuf_decode_queue_pkg.sv
// Shared definitions for the IF->ID instruction buffer: branch type codes,
// LoongArch branch opcodes and entry layout helpers.
package ibuf_decode_queue_pkg;

  localparam int BRANCH_TYPE_LEN = 4;
  localparam int BP_INFO_WIDTH   = 37;

  localparam logic [BRANCH_TYPE_LEN-1:0] DEFAULT_BRANCH_TYPE = 4'd0;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_BEQ          = 4'd1;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_BNE          = 4'd2;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_BLT          = 4'd3;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_BGE          = 4'd4;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_BLTU         = 4'd5;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_BGEU         = 4'd6;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_B            = 4'd7;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_BL           = 4'd8;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_JIRL         = 4'd9;

  // Major opcode field inst[31:26]
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;
  localparam logic [5:0] OP_BLT  = 6'h18;
  localparam logic [5:0] OP_BGE  = 6'h19;
  localparam logic [5:0] OP_BLTU = 6'h1a;
  localparam logic [5:0] OP_BGEU = 6'h1b;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_JIRL = 6'h13;

  // Stored entry is {bp_info, pc, inst}
  function automatic int ibuf_entry_wd(input int bp_w);
    return 64 + bp_w;
  endfunction

endpackage

// File: rtl/ibuf_decode_queue_if.sv
// Fetch-side push channel and decode-side multi-slot pop channel of the
// instruction buffer. slave = the buffer, master = fetch/decode environment.
interface ibuf_decode_queue_if
  import ibuf_decode_queue_pkg::*;
#(
  parameter int OUT_WIDTH = 2,
  parameter int BP_W      = BP_INFO_WIDTH
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [31:0]                          in_inst;
  logic [31:0]                          in_pc;
  logic [BP_W-1:0]                      in_bp_info;

  logic [OUT_WIDTH-1:0]                 out_valid;
  logic                                 out_ready;
  logic [OUT_WIDTH*32-1:0]              out_inst;
  logic [OUT_WIDTH*32-1:0]              out_pc;
  logic [OUT_WIDTH*BP_W-1:0]            out_bp_info;
  logic [OUT_WIDTH-1:0]                 out_is_branch;
  logic [OUT_WIDTH*BRANCH_TYPE_LEN-1:0] out_br_type;

  modport slave (
    input  in_valid, in_inst, in_pc, in_bp_info, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_bp_info,
           out_is_branch, out_br_type
  );

  modport master (
    output in_valid, in_inst, in_pc, in_bp_info, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_bp_info,
           out_is_branch, out_br_type
  );
endinterface

// File: rtl/ibuf_decode_queue_branch_predecode.sv
// Classifies one instruction word by its major opcode into a branch type.
module branch_predecode
  import ibuf_decode_queue_pkg::*;
(
  input  logic [31:0]                inst,
  output logic                       is_branch,
  output logic [BRANCH_TYPE_LEN-1:0] br_type
);
  // Only the major opcode matters; the rest of the word is ignored here.
  logic unused_low_bits;
  assign unused_low_bits = ^inst[25:0];

  // Opcode lookup; anything unrecognised is a non-branch.
  always_comb begin
    is_branch = 1'b1;
    br_type   = DEFAULT_BRANCH_TYPE;
    case (inst[31:26])
      OP_BEQ:  br_type = BRANCH_BEQ;
      OP_BNE:  br_type = BRANCH_BNE;
      OP_BLT:  br_type = BRANCH_BLT;
      OP_BGE:  br_type = BRANCH_BGE;
      OP_BLTU: br_type = BRANCH_BLTU;
      OP_BGEU: br_type = BRANCH_BGEU;
      OP_B:    br_type = BRANCH_B;
      OP_BL:   br_type = BRANCH_BL;
      OP_JIRL: br_type = BRANCH_JIRL;
      default: is_branch = 1'b0;
    endcase
  end
endmodule

// File: rtl/ibuf_decode_queue.sv
// Circular instruction buffer between fetch and decode. Presents up to
// OUT_WIDTH oldest entries per cycle, pre-decoded for branch class.
module ibuf_decode_queue
  import ibuf_decode_queue_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int OUT_WIDTH   = 2,
  parameter int BP_W        = BP_INFO_WIDTH,
  parameter int PAIR_BRANCH = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     br_kill,
  input  logic                     stall,
  ibuf_decode_queue_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int ENTRY_WD = ibuf_entry_wd(BP_W);

  logic [ENTRY_WD-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]     head_reg, head_next;
  logic [PTR_W-1:0]     tail_reg, tail_next;
  logic [CNT_W-1:0]     count_reg, count_next;

  logic                 kill;
  logic                 push;
  logic                 pop;
  logic [CNT_W-1:0]     pop_n;
  logic [OUT_WIDTH-1:0] slot_valid;
  logic [OUT_WIDTH-1:0] slot_is_br;

  assign kill         = flush | br_kill;
  // Depends on occupancy only: a full queue refuses even if a pop is pending.
  assign bus.in_ready = (count_reg != CNT_W'(DEPTH));
  assign push         = bus.in_valid & bus.in_ready & ~kill;
  assign pop          = bus.out_ready & ~stall & ~kill & slot_valid[0];
  assign bus.out_valid = slot_valid;
  assign count         = count_reg;

  // Per-slot read port, pre-decode and output packing.
  genvar gi;
  for (gi = 0; gi < OUT_WIDTH; gi++) begin : g_slot
    logic [PTR_W-1:0]    idx;
    logic [ENTRY_WD-1:0] entry;
    assign idx   = head_reg + PTR_W'(gi);
    assign entry = mem[idx];
    assign bus.out_inst[gi*32 +: 32]       = entry[31:0];
    assign bus.out_pc[gi*32 +: 32]         = entry[63:32];
    assign bus.out_bp_info[gi*BP_W +: BP_W] = entry[ENTRY_WD-1:64];
    assign bus.out_is_branch[gi]           = slot_is_br[gi];
    branch_predecode u_predecode (
      .inst      (entry[31:0]),
      .is_branch (slot_is_br[gi]),
      .br_type   (bus.out_br_type[gi*BRANCH_TYPE_LEN +: BRANCH_TYPE_LEN])
    );
  end

  // Thermometer slot valids from occupancy; slot 1 yields to a lone branch.
  // Valids come from count only, so stale entry data can never make them X.
  always_comb begin
    slot_valid    = '0;
    slot_valid[0] = (count_reg != '0);
    if (OUT_WIDTH == 2) begin
      slot_valid[OUT_WIDTH-1] = (count_reg >= CNT_W'(2)) &&
                                ((PAIR_BRANCH != 0) || !slot_is_br[0]);
    end
  end

  // Number of entries the decoder takes when it pops.
  always_comb begin
    pop_n = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      pop_n = pop_n + CNT_W'(slot_valid[i]);
    end
  end

  // Pointer / occupancy update; a kill wins over any push or pop.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (kill) begin
      head_next  = tail_reg;
      count_next = '0;
    end else begin
      if (push) tail_next = tail_reg + PTR_W'(1);
      if (pop)  head_next = head_reg + pop_n[PTR_W-1:0];
      count_next = count_reg + CNT_W'(push) - (pop ? pop_n : '0);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[tail_reg] <= {bus.in_bp_info, bus.in_pc, bus.in_inst};
    end
  end
endmodule

// File: tb/tb_ibuf_decode_queue.sv
// Scoreboard bench for ibuf_decode_queue: stimulus pushes expected entries
// and status expectations into queues; a negedge monitor checks the DUT.
module tb_ibuf_decode_queue;
  import ibuf_decode_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int OW    = 2;
  localparam int BPW   = 37;

  logic clk;
  logic reset;
  logic flush, br_kill, stall;
  logic [3:0] count, count2;

  ibuf_decode_queue_if #(.OUT_WIDTH(OW), .BP_W(BPW)) bus ();
  ibuf_decode_queue_if #(.OUT_WIDTH(OW), .BP_W(BPW)) bus2 ();

  // Second instance (branch pairing allowed) shadows the same inputs.
  assign bus2.in_valid   = bus.in_valid;
  assign bus2.in_inst    = bus.in_inst;
  assign bus2.in_pc      = bus.in_pc;
  assign bus2.in_bp_info = bus.in_bp_info;
  assign bus2.out_ready  = bus.out_ready;

  ibuf_decode_queue #(.DEPTH(DEPTH), .OUT_WIDTH(OW), .BP_W(BPW), .PAIR_BRANCH(0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .br_kill(br_kill), .stall(stall),
    .bus(bus), .count(count)
  );

  ibuf_decode_queue #(.DEPTH(DEPTH), .OUT_WIDTH(OW), .BP_W(BPW), .PAIR_BRANCH(1)) dut_pair (
    .clk(clk), .reset(reset), .flush(flush), .br_kill(br_kill), .stall(stall),
    .bus(bus2), .count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   inst;
    logic [BPW-1:0] bp;
    logic          is_br;
    logic [3:0]    br_type;
  } exp_t;

  typedef struct {
    int         cnt;
    logic       rdy;
    logic       chk2;
    logic [1:0] v2;
    int         cnt2;
  } stat_t;

  exp_t  exp_q[$];
  stat_t stat_q[$];
  string stat_name[$];
  exp_t  cur;
  logic  mon_en;
  int    errors;
  int    checks;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare presented slots and status against the scoreboard.
  always @(negedge clk) begin
    int   n;
    exp_t e;
    if (mon_en && !reset) begin
      n = 0;
      if (exp_q.size() >= 1) n = 1;
      if (exp_q.size() >= 2 && !exp_q[0].is_br) n = 2;
      chk("out_valid", 64'(bus.out_valid), (n == 2) ? 64'd3 : 64'(n));
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() != DEPTH));
      for (int i = 0; i < n; i++) begin
        e = exp_q[i];
        chk($sformatf("slot%0d_pc", i), 64'(bus.out_pc[i*32 +: 32]), 64'(e.pc));
        chk($sformatf("slot%0d_inst", i), 64'(bus.out_inst[i*32 +: 32]), 64'(e.inst));
        chk($sformatf("slot%0d_bp", i), 64'(bus.out_bp_info[i*BPW +: BPW]), 64'(e.bp));
        chk($sformatf("slot%0d_brtype", i),
            64'({bus.out_is_branch[i], bus.out_br_type[i*4 +: 4]}),
            64'({e.is_br, e.br_type}));
      end
      if (stat_q.size() > 0) begin
        stat_t s;
        string nm;
        s  = stat_q.pop_front();
        nm = stat_name.pop_front();
        chk({nm, "_count"}, 64'(count), 64'(s.cnt));
        chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'(s.rdy));
        if (s.chk2) begin
          chk({nm, "_pair_valid"}, 64'(bus2.out_valid), 64'(s.v2));
          chk({nm, "_pair_count"}, 64'(count2), 64'(s.cnt2));
        end
      end
      if (n > 0 && bus.out_ready && !stall && !flush && !br_kill) begin
        for (int i = 0; i < n; i++) void'(exp_q.pop_front());
      end
    end
  end

  // One clock with the currently driven inputs; updates the model at the edge.
  task automatic step();
    logic acc, kill, rst_now;
    @(negedge clk);
    acc     = bus.in_valid && bus.in_ready && !flush && !br_kill;
    kill    = flush || br_kill;
    rst_now = reset;
    @(posedge clk);
    if (rst_now || kill) exp_q.delete();
    else if (acc) exp_q.push_back(cur);
    #1;
  endtask

  task automatic expect_status(input string name, input int cnt, input logic rdy);
    stat_t s;
    s.cnt = cnt; s.rdy = rdy; s.chk2 = 1'b0; s.v2 = 2'b00; s.cnt2 = 0;
    stat_q.push_back(s);
    stat_name.push_back(name);
  endtask

  task automatic expect_pair(input string name, input int cnt, input logic [1:0] v2, input int cnt2);
    stat_t s;
    s.cnt = cnt; s.rdy = 1'b1; s.chk2 = 1'b1; s.v2 = v2; s.cnt2 = cnt2;
    stat_q.push_back(s);
    stat_name.push_back(name);
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [31:0] inst,
                        input logic is_br, input logic [3:0] bt);
    bus.in_valid   = 1'b1;
    bus.in_pc      = pc;
    bus.in_inst    = inst;
    bus.in_bp_info = {5'h15, ~pc};
    cur.pc = pc; cur.inst = inst; cur.bp = {5'h15, ~pc};
    cur.is_br = is_br; cur.br_type = bt;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst,
                          input logic is_br, input logic [3:0] bt);
    set_in(pc, inst, is_br, bt);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Non-branch (add.w-style) instruction tagged with k in its low bits.
  function automatic logic [31:0] alu_inst(input int k);
    return 32'h0010_0000 | 32'(k);
  endfunction

  // Directed branch vectors: {inst, expected type}
  logic [31:0] br_inst [9];
  logic [3:0]  br_exp  [9];
  logic        br_isb  [9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; mon_en = 1'b0;
    reset = 1'b1; flush = 1'b0; br_kill = 1'b0; stall = 1'b0;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.in_bp_info = '0;
    bus.out_ready = 1'b0;
    cur = '{default: '0};

    br_inst[0] = 32'h5c00_0123; br_exp[0] = BRANCH_BNE;  br_isb[0] = 1'b1;
    br_inst[1] = 32'h6000_0123; br_exp[1] = BRANCH_BLT;  br_isb[1] = 1'b1;
    br_inst[2] = 32'h6400_0123; br_exp[2] = BRANCH_BGE;  br_isb[2] = 1'b1;
    br_inst[3] = 32'h6800_0123; br_exp[3] = BRANCH_BLTU; br_isb[3] = 1'b1;
    br_inst[4] = 32'h6c00_0123; br_exp[4] = BRANCH_BGEU; br_isb[4] = 1'b1;
    br_inst[5] = 32'h5000_0123; br_exp[5] = BRANCH_B;    br_isb[5] = 1'b1;
    br_inst[6] = 32'h5400_0123; br_exp[6] = BRANCH_BL;   br_isb[6] = 1'b1;
    br_inst[7] = 32'h4c00_0123; br_exp[7] = BRANCH_JIRL; br_isb[7] = 1'b1;
    br_inst[8] = 32'h7000_0123; br_exp[8] = DEFAULT_BRANCH_TYPE; br_isb[8] = 1'b0;

    step(); step();
    reset = 1'b0;
    mon_en = 1'b1;
    expect_status("reset", 0, 1'b1);

    // Fill to full with decoder stalled, then drain in pairs.
    for (int k = 0; k < 8; k++) push_one(32'h1c00_0000 + 32'(4*k), alu_inst(k), 1'b0, DEFAULT_BRANCH_TYPE);
    expect_status("fill", 8, 1'b0);
    bus.out_ready = 1'b1;
    repeat (4) step();
    expect_status("drain", 0, 1'b1);

    // Move head to 7, then straddle the wrap with 3 entries and pop 2.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 7; k++) push_one(32'h1c00_1000 + 32'(4*k), alu_inst(k + 16), 1'b0, DEFAULT_BRANCH_TYPE);
    bus.out_ready = 1'b1;
    repeat (4) step();
    expect_status("pre_wrap", 0, 1'b1);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_one(32'h1c00_2000 + 32'(4*k), alu_inst(k + 32), 1'b0, DEFAULT_BRANCH_TYPE);
    expect_status("wrap_fill", 3, 1'b1);
    bus.out_ready = 1'b1;
    step();
    expect_status("wrap_pop2", 1, 1'b1);
    step();
    expect_status("wrap_empty", 0, 1'b1);

    // Kill mid-stream: push in the same cycle as br_kill is dropped.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_one(32'h1c00_3000 + 32'(4*k), alu_inst(k + 48), 1'b0, DEFAULT_BRANCH_TYPE);
    expect_status("kill_pre", 5, 1'b1);
    set_in(32'hdead_0000, alu_inst(99), 1'b0, DEFAULT_BRANCH_TYPE);
    br_kill = 1'b1;
    step();
    br_kill = 1'b0; bus.in_valid = 1'b0;
    expect_status("kill_post", 0, 1'b1);
    step();

    // flush and br_kill together behave as one kill.
    for (int k = 0; k < 2; k++) push_one(32'h1c00_4000 + 32'(4*k), alu_inst(k + 64), 1'b0, DEFAULT_BRANCH_TYPE);
    flush = 1'b1; br_kill = 1'b1;
    step();
    flush = 1'b0; br_kill = 1'b0;
    expect_status("flush_both", 0, 1'b1);

    // Full + pop: push refused, two entries leave.
    for (int k = 0; k < 8; k++) push_one(32'h1c00_5000 + 32'(4*k), alu_inst(k + 80), 1'b0, DEFAULT_BRANCH_TYPE);
    expect_status("full", 8, 1'b0);
    set_in(32'hbeef_0000, alu_inst(98), 1'b0, DEFAULT_BRANCH_TYPE);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    expect_status("full_pop", 6, 1'b1);
    repeat (3) step();
    expect_status("full_drain", 0, 1'b1);

    // Stall holds outputs and count; release pops a pair.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_one(32'h1c00_6000 + 32'(4*k), alu_inst(k + 96), 1'b0, DEFAULT_BRANCH_TYPE);
    expect_status("stall_pre", 3, 1'b1);
    stall = 1'b1; bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_status("stall_hold", 3, 1'b1);
    end
    stall = 1'b0;
    step();
    expect_status("stall_release", 1, 1'b1);
    step();
    expect_status("stall_empty", 0, 1'b1);

    // Branch pairing: beq then add.w; pairing instance shows both slots.
    bus.out_ready = 1'b0;
    push_one(32'h1c00_7000, 32'h5800_0401, 1'b1, BRANCH_BEQ);
    push_one(32'h1c00_7004, alu_inst(7), 1'b0, DEFAULT_BRANCH_TYPE);
    expect_pair("pair_pre", 2, 2'b11, 2);
    bus.out_ready = 1'b1;
    step();
    expect_pair("pair_pop", 1, 2'b00, 0);
    step();
    expect_status("pair_empty", 0, 1'b1);

    // Every branch opcode plus a neighbouring non-branch, decoder running.
    for (int k = 0; k < 9; k++) push_one(32'h1c00_8000 + 32'(4*k), br_inst[k], br_isb[k], br_exp[k]);
    repeat (4) step();
    expect_status("br_drain", 0, 1'b1);
    step(); step();

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
